// File: rtl/alu_exec_if.sv
// Operand/handshake bus between the ID/EX register and the execute-stage ALU.
// master = pipeline side driving operations, slave = ALU.
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [7:0]       alucontrol;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             out_valid;
    logic             busy;

    modport master (
        output in_valid, flush, alucontrol, a, b,
        input  in_ready, result, overflow, out_valid, busy
    );

    modport slave (
        input  in_valid, flush, alucontrol, a, b,
        output in_ready, result, overflow, out_valid, busy
    );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle logic/arith ops, registered result with a one-cycle valid pulse.
// Define ALU_MULDIV_EN to add HI/LO and the iterative shift-add multiply / restoring divide.
module alu_exec #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic      clk,
    input  logic      resetn,
    alu_exec_if.slave bus
);
    localparam logic [7:0] AND_OP   = 8'b0010_0100;
    localparam logic [7:0] OR_OP    = 8'b0010_0101;
    localparam logic [7:0] XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] ANDI_OP  = 8'b0101_1001;
    localparam logic [7:0] XORI_OP  = 8'b0101_1010;
    localparam logic [7:0] LUI_OP   = 8'b0101_1100;
    localparam logic [7:0] ORI_OP   = 8'b0101_1101;
    localparam logic [7:0] ADD_OP   = 8'b0010_0000;
    localparam logic [7:0] ADDU_OP  = 8'b0010_0001;
    localparam logic [7:0] SUB_OP   = 8'b0010_0010;
    localparam logic [7:0] SUBU_OP  = 8'b0010_0011;
    localparam logic [7:0] SLT_OP   = 8'b0010_1010;
    localparam logic [7:0] SLTU_OP  = 8'b0010_1011;
    localparam logic [7:0] MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] DIVU_OP  = 8'b0001_1011;
    localparam logic [7:0] MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] MTLO_OP  = 8'b0001_0011;

    if (ITERS != WIDTH) begin : g_iters_check
        $error("alu_exec: ITERS must equal WIDTH");
    end

    logic [WIDTH-1:0] a, b, sum, diff, alu_res, hi_rd, lo_rd, imm_zx;
    logic             ovf_add, ovf_sub, alu_ovf, lt_s, lt_u, in_ready, accept;
    logic [WIDTH-1:0] result_q;
    logic             overflow_q, out_valid_q;

    assign a       = bus.a;
    assign b       = bus.b;
    assign sum     = a + b;
    assign diff    = a - b;
    assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    assign lt_s    = $signed(a) < $signed(b);
    assign lt_u    = a < b;
    assign imm_zx  = {{(WIDTH-16){1'b0}}, b[15:0]};
    assign accept  = bus.in_valid & in_ready & ~bus.flush;

    always_comb begin
        alu_res = sum;
        alu_ovf = 1'b0;
        case (bus.alucontrol)
            ADD_OP:   begin alu_res = sum;  alu_ovf = ovf_add; end
            SUB_OP:   begin alu_res = diff; alu_ovf = ovf_sub; end
            SUBU_OP:  alu_res = diff;
            SLT_OP:   alu_res = {{(WIDTH-1){1'b0}}, lt_s};
            SLTU_OP:  alu_res = {{(WIDTH-1){1'b0}}, lt_u};
            AND_OP:   alu_res = a & b;
            OR_OP:    alu_res = a | b;
            XOR_OP:   alu_res = a ^ b;
            NOR_OP:   alu_res = ~(a | b);
            ANDI_OP:  alu_res = a & imm_zx;
            ORI_OP:   alu_res = a | imm_zx;
            XORI_OP:  alu_res = a ^ imm_zx;
            LUI_OP:   alu_res = {b[15:0], {(WIDTH-16){1'b0}}};
            MFHI_OP:  alu_res = hi_rd;
            MFLO_OP:  alu_res = lo_rd;
            MTHI_OP, MTLO_OP, MULT_OP, MULTU_OP, DIV_OP, DIVU_OP: alu_res = '0;
            default:  alu_res = sum;
        endcase
    end

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

    state_t             state_q;
    logic [5:0]         cnt_q;
    logic [2*WIDTH-1:0] p_q, p_d, prod_fix;
    logic [WIDTH-1:0]   m_q, hi_q, lo_q, a_mag, b_mag, quo_fix, rem_fix;
    logic               neg_lo_q, neg_hi_q, busy_q;
    logic               is_mul, is_div, sgn, a_neg, b_neg;
    logic [WIDTH:0]     mul_sum, div_trial;

    assign is_mul = (bus.alucontrol == MULT_OP) || (bus.alucontrol == MULTU_OP);
    assign is_div = (bus.alucontrol == DIV_OP)  || (bus.alucontrol == DIVU_OP);
    assign sgn    = (bus.alucontrol == MULT_OP) || (bus.alucontrol == DIV_OP);
    assign a_neg  = sgn & a[WIDTH-1];
    assign b_neg  = sgn & b[WIDTH-1];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;

    // p_q holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    assign mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? m_q : {WIDTH{1'b0}})};
    assign div_trial = p_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};

    always_comb begin
        if (state_q == S_MUL)
            p_d = {mul_sum, p_q[WIDTH-1:1]};
        else if (div_trial[WIDTH])
            p_d = {p_q[2*WIDTH-2:0], 1'b0};
        else
            p_d = {div_trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    end

    assign prod_fix = neg_lo_q ? -p_d : p_d;
    assign quo_fix  = neg_lo_q ? -p_d[WIDTH-1:0] : p_d[WIDTH-1:0];
    assign rem_fix  = neg_hi_q ? -p_d[2*WIDTH-1:WIDTH] : p_d[2*WIDTH-1:WIDTH];
    assign hi_rd    = hi_q;
    assign lo_rd    = lo_q;
    assign in_ready = (state_q == S_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            m_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cnt_q <= '0;
                        if (is_mul || is_div) begin
                            state_q  <= is_mul ? S_MUL : S_DIV;
                            busy_q   <= 1'b1;
                            p_q      <= {{WIDTH{1'b0}}, (is_mul ? b_mag : a_mag)};
                            m_q      <= is_mul ? a_mag : b_mag;
                            // a zero divisor keeps the all-ones quotient unsigned
                            neg_lo_q <= (a_neg ^ b_neg) & (is_mul | (|b));
                            neg_hi_q <= a_neg;
                        end else begin
                            result_q    <= alu_res;
                            overflow_q  <= alu_ovf;
                            out_valid_q <= 1'b1;
                            if (bus.alucontrol == MTHI_OP) hi_q <= a;
                            if (bus.alucontrol == MTLO_OP) lo_q <= a;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (bus.flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        p_q   <= p_d;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'(ITERS-1)) begin
                            state_q     <= S_FIN;
                            out_valid_q <= 1'b1;
                            overflow_q  <= 1'b0;
                            if (state_q == S_MUL) begin
                                hi_q     <= prod_fix[2*WIDTH-1:WIDTH];
                                lo_q     <= prod_fix[WIDTH-1:0];
                                result_q <= prod_fix[WIDTH-1:0];
                            end else begin
                                hi_q     <= rem_fix;
                                lo_q     <= quo_fix;
                                result_q <= quo_fix;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
`else
    assign hi_rd    = '0;
    assign lo_rd    = '0;
    assign in_ready = 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result_q    <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                result_q   <= alu_res;
                overflow_q <= alu_ovf;
            end
        end
    end

    assign bus.busy = 1'b0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec; mul/div expectations follow ALU_MULDIV_EN.
module tb_alu_exec;
    localparam logic [7:0] AND_OP   = 8'b0010_0100;
    localparam logic [7:0] OR_OP    = 8'b0010_0101;
    localparam logic [7:0] XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] ANDI_OP  = 8'b0101_1001;
    localparam logic [7:0] XORI_OP  = 8'b0101_1010;
    localparam logic [7:0] LUI_OP   = 8'b0101_1100;
    localparam logic [7:0] ORI_OP   = 8'b0101_1101;
    localparam logic [7:0] ADD_OP   = 8'b0010_0000;
    localparam logic [7:0] ADDU_OP  = 8'b0010_0001;
    localparam logic [7:0] SUB_OP   = 8'b0010_0010;
    localparam logic [7:0] SUBU_OP  = 8'b0010_0011;
    localparam logic [7:0] SLT_OP   = 8'b0010_1010;
    localparam logic [7:0] SLTU_OP  = 8'b0010_1011;
    localparam logic [7:0] MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] DIVU_OP  = 8'b0001_1011;
    localparam logic [7:0] MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] MTLO_OP  = 8'b0001_0011;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    alu_exec_if #(.WIDTH(32)) alu_bus ();

    alu_exec #(.WIDTH(32), .ITERS(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (alu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

    // Present one operation for exactly one accepting edge; returns 1ns after that edge.
    task automatic issue(input logic [7:0] op, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        alu_bus.in_valid   = 1'b1;
        alu_bus.alucontrol = op;
        alu_bus.a          = av;
        alu_bus.b          = bv;
        @(posedge clk);
        #1;
        alu_bus.in_valid   = 1'b0;
        $display("op=%02h a=%08h b=%08h -> out_valid=%0b result=%08h ovf=%0b busy=%0b",
                 op, av, bv, alu_bus.out_valid, alu_bus.result, alu_bus.overflow, alu_bus.busy);
    endtask

    task automatic test_reset();
        resetn             = 1'b0;
        alu_bus.in_valid   = 1'b0;
        alu_bus.flush      = 1'b0;
        alu_bus.alucontrol = ADDU_OP;
        alu_bus.a          = '0;
        alu_bus.b          = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (alu_bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %08h want 00000000", alu_bus.result); end
        checks++; if (alu_bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", alu_bus.overflow); end
        checks++; if (alu_bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", alu_bus.out_valid); end
        checks++; if (alu_bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", alu_bus.busy); end
        checks++; if (alu_bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", alu_bus.in_ready); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_single_cycle();
        logic [7:0]  ops [17] = '{ADD_OP, ADDU_OP, SUB_OP, SUBU_OP, SLT_OP, SLTU_OP, LUI_OP, ORI_OP,
                                  ANDI_OP, XORI_OP, AND_OP, OR_OP, XOR_OP, NOR_OP, 8'hFF, ADD_OP, SUB_OP};
        logic [31:0] av [17]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h0000FFFF,
                                  32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h00000002,
                                  32'h80000000, 32'h00000005};
        logic [31:0] bv [17]  = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001,
                                  32'h00000001, 32'h0000ABCD, 32'hFFFF8001, 32'hFFFF00F0, 32'hFFFFFF00,
                                  32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'h00000003,
                                  32'hFFFFFFFF, 32'h00000007};
        logic [31:0] rv [17]  = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000001,
                                  32'h00000000, 32'hABCD0000, 32'h00008001, 32'h000000F0, 32'h000000FF,
                                  32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h000F000F, 32'h00000005,
                                  32'h7FFFFFFF, 32'hFFFFFFFE};
        logic        ov [17]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 17; i++) begin
            issue(ops[i], av[i], bv[i]);
            checks++; if (alu_bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %0b want 1", i, alu_bus.out_valid); end
            checks++; if (alu_bus.result !== rv[i]) begin errors++; $display("FAIL single_result[%0d]: got %08h want %08h", i, alu_bus.result, rv[i]); end
            checks++; if (alu_bus.overflow !== ov[i]) begin errors++; $display("FAIL single_overflow[%0d]: got %0b want %0b", i, alu_bus.overflow, ov[i]); end
        end
        @(posedge clk);
        #1;
        checks++; if (alu_bus.out_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %0b want 0", alu_bus.out_valid); end
    endtask

    task automatic test_muldiv();
        logic [7:0]  ops [6] = '{MULT_OP, MULTU_OP, DIV_OP, DIVU_OP, DIV_OP, DIV_OP};
        logic [31:0] av [6]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h00000005, 32'h00000007, 32'hFFFFFFF9};
        logic [31:0] bv [6]  = '{32'h00000003, 32'h00000002, 32'h00000002, 32'h00000000, 32'hFFFFFFFE, 32'h00000000};
        logic [31:0] lov [6] = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF};
        logic [31:0] hiv [6] = '{32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000005, 32'h00000001, 32'hFFFFFFF9};
        int n;
        int stray;
        for (int i = 0; i < 6; i++) begin
`ifdef ALU_MULDIV_EN
            issue(ops[i], av[i], bv[i]);
            checks++; if (alu_bus.busy !== 1'b1) begin errors++; $display("FAIL md_busy_start[%0d]: got %0b want 1", i, alu_bus.busy); end
            checks++; if (alu_bus.in_ready !== 1'b0) begin errors++; $display("FAIL md_ready_start[%0d]: got %0b want 0", i, alu_bus.in_ready); end
            alu_bus.in_valid   = 1'b1;
            alu_bus.alucontrol = ADD_OP;
            alu_bus.a          = 32'h1;
            alu_bus.b          = 32'h1;
            n     = 1;
            stray = 0;
            while (alu_bus.out_valid !== 1'b1 && n < 40) begin
                if (n == 4) alu_bus.in_valid = 1'b0;
                if (alu_bus.busy !== 1'b1 || alu_bus.in_ready !== 1'b0) stray++;
                @(posedge clk);
                #1;
                n++;
            end
            alu_bus.in_valid = 1'b0;
            checks++; if (n !== 33) begin errors++; $display("FAIL md_latency[%0d]: got %0d want 33", i, n); end
            checks++; if (alu_bus.result !== lov[i]) begin errors++; $display("FAIL md_result[%0d]: got %08h want %08h", i, alu_bus.result, lov[i]); end
            checks++; if (alu_bus.busy !== 1'b1) begin errors++; $display("FAIL md_busy_fin[%0d]: got %0b want 1", i, alu_bus.busy); end
            checks++; if (stray !== 0) begin errors++; $display("FAIL md_busy_hold[%0d]: got %0d bad cycles want 0", i, stray); end
            @(posedge clk);
            #1;
            checks++; if (alu_bus.busy !== 1'b0 || alu_bus.in_ready !== 1'b1) begin errors++; $display("FAIL md_release[%0d]: got busy=%0b ready=%0b want busy=0 ready=1", i, alu_bus.busy, alu_bus.in_ready); end
            issue(MFHI_OP, 32'h0, 32'h0);
            checks++; if (alu_bus.result !== hiv[i]) begin errors++; $display("FAIL md_hi[%0d]: got %08h want %08h", i, alu_bus.result, hiv[i]); end
            issue(MFLO_OP, 32'h0, 32'h0);
            checks++; if (alu_bus.result !== lov[i]) begin errors++; $display("FAIL md_lo[%0d]: got %08h want %08h", i, alu_bus.result, lov[i]); end
`else
            issue(ops[i], av[i], bv[i]);
            checks++; if (alu_bus.out_valid !== 1'b1) begin errors++; $display("FAIL md_valid[%0d]: got %0b want 1", i, alu_bus.out_valid); end
            checks++; if (alu_bus.result !== 32'h0) begin errors++; $display("FAIL md_result[%0d]: got %08h want 00000000 (lo ref %08h hi ref %08h)", i, alu_bus.result, lov[i], hiv[i]); end
            checks++; if (alu_bus.busy !== 1'b0 || alu_bus.in_ready !== 1'b1) begin errors++; $display("FAIL md_busy[%0d]: got busy=%0b ready=%0b want busy=0 ready=1", i, alu_bus.busy, alu_bus.in_ready); end
            n = 0; stray = 0;
`endif
        end
    endtask

    task automatic test_flush();
        int vcount;
        issue(MTLO_OP, 32'h00001234, 32'h0);
        checks++; if (alu_bus.result !== 32'h0) begin errors++; $display("FAIL mtlo_result: got %08h want 00000000", alu_bus.result); end
        @(negedge clk);
        alu_bus.in_valid   = 1'b1;
        alu_bus.flush      = 1'b1;
        alu_bus.alucontrol = ADD_OP;
        alu_bus.a          = 32'h5;
        alu_bus.b          = 32'h6;
        @(posedge clk);
        #1;
        alu_bus.in_valid = 1'b0;
        alu_bus.flush    = 1'b0;
        $display("op=%02h flush with in_valid -> out_valid=%0b busy=%0b", ADD_OP, alu_bus.out_valid, alu_bus.busy);
        checks++; if (alu_bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_blocks_accept: got out_valid=%0b want 0", alu_bus.out_valid); end
`ifdef ALU_MULDIV_EN
        issue(DIVU_OP, 32'd100, 32'd7);
        repeat (9) begin @(posedge clk); #1; end
        alu_bus.flush = 1'b1;
        @(posedge clk);
        #1;
        alu_bus.flush = 1'b0;
        checks++; if (alu_bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %0b want 0", alu_bus.busy); end
        checks++; if (alu_bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %0b want 1", alu_bus.in_ready); end
        vcount = 0;
        for (int k = 0; k < 30; k++) begin
            if (alu_bus.out_valid === 1'b1) vcount++;
            @(posedge clk);
            #1;
        end
        checks++; if (vcount !== 0) begin errors++; $display("FAIL flush_no_valid: got %0d pulses want 0", vcount); end
        issue(MFLO_OP, 32'h0, 32'h0);
        checks++; if (alu_bus.result !== 32'h00001234) begin errors++; $display("FAIL flush_lo_kept: got %08h want 00001234", alu_bus.result); end
`else
        vcount = 0;
        issue(MFLO_OP, 32'h0, 32'h0);
        checks++; if (alu_bus.result !== 32'h0) begin errors++; $display("FAIL mflo_disabled: got %08h want 00000000 (pulses %0d)", alu_bus.result, vcount); end
`endif
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        alu_bus.in_valid   = 1'b1;
        alu_bus.alucontrol = SUBU_OP;
        alu_bus.a          = 32'h00000010;
        alu_bus.b          = 32'h00000003;
        @(posedge clk); #1;
        alu_bus.alucontrol = XOR_OP;
        alu_bus.a          = 32'hAAAA5555;
        alu_bus.b          = 32'hFFFF0000;
        $display("b2b op=%02h -> out_valid=%0b result=%08h", SUBU_OP, alu_bus.out_valid, alu_bus.result);
        checks++; if (alu_bus.out_valid !== 1'b1 || alu_bus.result !== 32'h0000000D) begin errors++; $display("FAIL b2b_0: got v=%0b %08h want v=1 0000000D", alu_bus.out_valid, alu_bus.result); end
        @(posedge clk); #1;
        alu_bus.alucontrol = SLT_OP;
        alu_bus.a          = 32'h00000001;
        alu_bus.b          = 32'h80000000;
        $display("b2b op=%02h -> out_valid=%0b result=%08h", XOR_OP, alu_bus.out_valid, alu_bus.result);
        checks++; if (alu_bus.out_valid !== 1'b1 || alu_bus.result !== 32'h5555_5555) begin errors++; $display("FAIL b2b_1: got v=%0b %08h want v=1 55555555", alu_bus.out_valid, alu_bus.result); end
        @(posedge clk); #1;
        alu_bus.in_valid = 1'b0;
        $display("b2b op=%02h -> out_valid=%0b result=%08h", SLT_OP, alu_bus.out_valid, alu_bus.result);
        checks++; if (alu_bus.out_valid !== 1'b1 || alu_bus.result !== 32'h0) begin errors++; $display("FAIL b2b_2: got v=%0b %08h want v=1 00000000", alu_bus.out_valid, alu_bus.result); end
        @(posedge clk); #1;
        checks++; if (alu_bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %0b want 0", alu_bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        issue(ADDU_OP, 32'h00000100, 32'h00000023);
        checks++; if (alu_bus.result !== 32'h00000123) begin errors++; $display("FAIL premid_result: got %08h want 00000123", alu_bus.result); end
        issue(MULTU_OP, 32'h00001000, 32'h00000010);
        repeat (4) begin @(posedge clk); #1; end
`ifdef ALU_MULDIV_EN
        checks++; if (alu_bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %0b want 1", alu_bus.busy); end
`endif
        resetn = 1'b0;
        #1;
        $display("reset mid-op -> result=%08h out_valid=%0b busy=%0b ready=%0b", alu_bus.result, alu_bus.out_valid, alu_bus.busy, alu_bus.in_ready);
        checks++; if (alu_bus.result !== 32'h0) begin errors++; $display("FAIL mid_reset_result: got %08h want 00000000", alu_bus.result); end
        checks++; if (alu_bus.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %0b want 0", alu_bus.busy); end
        checks++; if (alu_bus.out_valid !== 1'b0 || alu_bus.overflow !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got v=%0b ovf=%0b want 0 0", alu_bus.out_valid, alu_bus.overflow); end
        checks++; if (alu_bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %0b want 1", alu_bus.in_ready); end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        issue(MFLO_OP, 32'h0, 32'h0);
        checks++; if (alu_bus.out_valid !== 1'b1 || alu_bus.result !== 32'h0) begin errors++; $display("FAIL post_reset_lo: got v=%0b %08h want v=1 00000000", alu_bus.out_valid, alu_bus.result); end
        issue(ADD_OP, 32'h2, 32'h3);
        checks++; if (alu_bus.out_valid !== 1'b1 || alu_bus.result !== 32'h5) begin errors++; $display("FAIL post_reset_add: got v=%0b %08h want v=1 00000005", alu_bus.out_valid, alu_bus.result); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_cycle();
        test_muldiv();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
